// File: rtl/rotate_arbiter_seq_16_if.sv
// Request/result bus for rotate_arbiter_seq_16: two command requesters and one tagged result port.
// The master side drives commands and out_ready; the slave side is the arbiter.
interface rotate_arbiter_seq_16_if #(
  parameter int PASS_W = 3
);
  logic              req0_valid;
  logic              req0_ready;
  logic [15:0]       req0_a;
  logic [3:0]        req0_amt;
  logic              req0_lr;
  logic [PASS_W-1:0] req0_passes;

  logic              req1_valid;
  logic              req1_ready;
  logic [15:0]       req1_a;
  logic [3:0]        req1_amt;
  logic              req1_lr;
  logic [PASS_W-1:0] req1_passes;

  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic              out_id;

  modport master (
    output req0_valid, req0_a, req0_amt, req0_lr, req0_passes,
    output req1_valid, req1_a, req1_amt, req1_lr, req1_passes,
    output out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_amt, req0_lr, req0_passes,
    input  req1_valid, req1_a, req1_amt, req1_lr, req1_passes,
    input  out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/rotate_arbiter_seq_16.sv
// Round-robin sequencer sharing one 16-bit rotator between two requesters, one pass per clock.
// Optional ROT_ARB_STATS_EN adds saturating per-id completion counters done_cnt0/done_cnt1.

module rotate_arbiter_seq_16_rot (
  input  logic [15:0] a,
  input  logic [3:0]  amt,
  input  logic        lr,
  output logic [15:0] y
);
  // Bit i of the result picks the source bit amt positions away, wrapping mod 16.
  always_comb begin
    y = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      y[i] = lr ? a[4'(i) - amt] : a[4'(i) + amt];
    end
  end
endmodule

module rotate_arbiter_seq_16 #(
  parameter int PASS_W = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  rotate_arbiter_seq_16_if.slave bus,
  output logic                   busy
`ifdef ROT_ARB_STATS_EN
  ,
  output logic [15:0]            done_cnt0,
  output logic [15:0]            done_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state;
  logic [15:0]       data_r;
  logic [3:0]        amt_r;
  logic              lr_r;
  logic [PASS_W-1:0] cnt_r;
  logic              id_r;
  logic              last_id;
  logic              out_valid_r;
  logic [15:0]       out_data_r;
  logic              out_id_r;
  logic [15:0]       rot_y;
  logic              grant0;
  logic              grant1;

  rotate_arbiter_seq_16_rot u_rot (
    .a   (data_r),
    .amt (amt_r),
    .lr  (lr_r),
    .y   (rot_y)
  );

  // last_id holds the requester served most recently; the other one wins a tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      grant0 = bus.req0_valid & (~bus.req1_valid | last_id);
      grant1 = bus.req1_valid & (~bus.req0_valid | ~last_id);
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_id     = out_id_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      data_r      <= '0;
      amt_r       <= '0;
      lr_r        <= 1'b0;
      cnt_r       <= '0;
      id_r        <= 1'b0;
      last_id     <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_id_r    <= 1'b0;
      busy        <= 1'b0;
`ifdef ROT_ARB_STATS_EN
      done_cnt0   <= '0;
      done_cnt1   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            data_r  <= grant1 ? bus.req1_a      : bus.req0_a;
            amt_r   <= grant1 ? bus.req1_amt    : bus.req0_amt;
            lr_r    <= grant1 ? bus.req1_lr     : bus.req0_lr;
            cnt_r   <= grant1 ? bus.req1_passes : bus.req0_passes;
            id_r    <= grant1;
            last_id <= grant1;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          data_r <= rot_y;
          // The last pass feeds the output register directly so out_data is ready with out_valid.
          if (cnt_r == '0) begin
            out_valid_r <= 1'b1;
            out_data_r  <= rot_y;
            out_id_r    <= id_r;
            state       <= DONE;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
`ifdef ROT_ARB_STATS_EN
            if (id_r) begin
              if (done_cnt1 != '1) done_cnt1 <= done_cnt1 + 16'd1;
            end else begin
              if (done_cnt0 != '1) done_cnt0 <= done_cnt0 + 16'd1;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_arbiter_seq_16.sv
// Self-checking bench for rotate_arbiter_seq_16: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_rotate_arbiter_seq_16;
  localparam int PASS_W = 3;

  logic clk = 1'b0;
  logic reset;
  logic busy;
`ifdef ROT_ARB_STATS_EN
  logic [15:0] done_cnt0;
  logic [15:0] done_cnt1;
`endif

  always #5 clk = ~clk;

  rotate_arbiter_seq_16_if #(.PASS_W(PASS_W)) bus ();

  rotate_arbiter_seq_16 #(.PASS_W(PASS_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
`ifdef ROT_ARB_STATS_EN
    ,
    .done_cnt0 (done_cnt0),
    .done_cnt1 (done_cnt1)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole rotation expressed as one left rotate by an accumulated amount.
  function automatic logic [15:0] ref_rot(input logic [15:0] a, input int amt, input bit left,
                                          input int times);
    int k;
    logic [31:0] w;
    k = ((left ? amt : (16 - amt)) * times) % 16;
    w = {16'h0, a} << k;
    return w[15:0] | w[31:16];
  endfunction

  // Reference model: phase 0 idle, 1 working, 2 result presented.
  int          m_phase = 0;
  int          m_timer = 0;
  logic [15:0] m_data = '0;
  bit          m_id = 0;
  bit          m_last = 1;
  int          m_cnt0 = 0;
  int          m_cnt1 = 0;
  bit          hs0_q = 0;
  bit          hs1_q = 0;
  bit          g0, g1;

  always @(negedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_last  = 1;
      m_cnt0  = 0;
      m_cnt1  = 0;
      hs0_q   = 0;
      hs1_q   = 0;
    end else begin
      hs0_q = 0;
      hs1_q = 0;
`ifdef ROT_ARB_STATS_EN
      check_val("done_cnt0", done_cnt0, m_cnt0);
      check_val("done_cnt1", done_cnt1, m_cnt1);
`endif
      if (m_phase == 0) begin
        g0 = bus.req0_valid && (!bus.req1_valid || m_last);
        g1 = bus.req1_valid && (!bus.req0_valid || !m_last);
        check_val("idle_ready0", bus.req0_ready, g0);
        check_val("idle_ready1", bus.req1_ready, g1);
        check_val("idle_busy", busy, 0);
        check_val("idle_out_valid", bus.out_valid, 0);
        if (g0 || g1) begin
          m_id    = g1;
          m_last  = g1;
          m_data  = g1 ? ref_rot(bus.req1_a, bus.req1_amt, bus.req1_lr, bus.req1_passes + 1)
                       : ref_rot(bus.req0_a, bus.req0_amt, bus.req0_lr, bus.req0_passes + 1);
          m_timer = 2 + (g1 ? int'(bus.req1_passes) : int'(bus.req0_passes));
          m_phase = 1;
          hs0_q   = g0;
          hs1_q   = g1;
        end
      end else begin
        check_val("busy_ready0", bus.req0_ready, 0);
        check_val("busy_ready1", bus.req1_ready, 0);
        check_val("busy_busy", busy, 1);
        if (m_phase == 1) begin
          m_timer--;
          if (m_timer == 0) m_phase = 2;
          else check_val("run_out_valid", bus.out_valid, 0);
        end
        if (m_phase == 2) begin
          check_val("done_out_valid", bus.out_valid, 1);
          check_val("done_out_data", bus.out_data, m_data);
          check_val("done_out_id", bus.out_id, m_id);
          if (bus.out_ready) begin
            if (m_id) m_cnt1++;
            else m_cnt0++;
            m_phase = 0;
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input bit v, input logic [15:0] a, input logic [3:0] amt,
                         input bit lr, input logic [PASS_W-1:0] passes);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_amt = amt;
      bus.req0_lr = lr; bus.req0_passes = passes;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_amt = amt;
      bus.req1_lr = lr; bus.req1_passes = passes;
    end
  endtask

  task automatic set_rand_req(input int id);
    set_req(id, 1, 16'($urandom), 4'($urandom), 1'($urandom), PASS_W'($urandom));
  endtask

  task automatic wait_accept(input int id);
    for (int i = 0; i < 60; i++) begin
      cycle();
      if ((id == 0 && hs0_q) || (id == 1 && hs1_q)) return;
    end
    check_val("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!busy && !bus.out_valid) return;
      cycle();
    end
    check_val("idle_timeout", 0, 1);
  endtask

  // One command from requester id with out_ready high; checks result value and latency.
  task automatic run_directed(input int id, input logic [15:0] a, input logic [3:0] amt,
                              input bit lr, input logic [PASS_W-1:0] passes,
                              input logic [15:0] exp_data, input int exp_lat);
    int lat;
    bus.out_ready = 1;
    set_req(id, 1, a, amt, lr, passes);
    wait_accept(id);
    set_req(id, 0, '0, '0, 0, '0);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      cycle();
      lat++;
    end
    check_val("dir_latency", lat, exp_lat);
    check_val("dir_data", bus.out_data, exp_data);
    check_val("dir_id", bus.out_id, id);
    cycle();
    check_val("dir_valid_one_cycle", bus.out_valid, 0);
    wait_idle();
  endtask

  initial begin
    int grants[$];
    logic [15:0] held_data;

    reset = 1;
    bus.out_ready = 0;
    set_req(0, 0, '0, '0, 0, '0);
    set_req(1, 0, '0, '0, 0, '0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_data", bus.out_data, 16'h0000);
    check_val("rst_out_id", bus.out_id, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ready0", bus.req0_ready, 0);
    check_val("rst_ready1", bus.req1_ready, 0);

    run_directed(0, 16'h8001, 4'd1, 0, 3'd0, 16'hC000, 2);
    run_directed(1, 16'h1234, 4'd4, 1, 3'd1, 16'h3412, 3);
    run_directed(0, 16'hBEEF, 4'd0, 0, 3'd7, 16'hBEEF, 9);

    // Contention straight after reset: grants must alternate starting with requester 0.
    reset = 1;
    cycle();
    reset = 0;
    bus.out_ready = 1;
    set_req(0, 1, 16'h0F0F, 4'd3, 0, 3'd0);
    set_req(1, 1, 16'hA5A5, 4'd5, 1, 3'd0);
    for (int i = 0; i < 60 && grants.size() < 6; i++) begin
      cycle();
      if (hs0_q) begin grants.push_back(0); set_req(0, 1, 16'($urandom), 4'($urandom), 0, 3'd0); end
      if (hs1_q) begin grants.push_back(1); set_req(1, 1, 16'($urandom), 4'($urandom), 1, 3'd0); end
    end
    check_val("contention_count", grants.size(), 6);
    foreach (grants[k]) check_val("contention_order", grants[k], k % 2);
    set_req(0, 0, '0, '0, 0, '0);
    set_req(1, 0, '0, '0, 0, '0);
    wait_idle();

    // Backpressure: result held while out_ready is low, waiting requester not granted.
    bus.out_ready = 0;
    set_req(0, 1, 16'h00F0, 4'd4, 0, 3'd0);
    wait_accept(0);
    set_req(0, 0, '0, '0, 0, '0);
    set_req(1, 1, 16'h1111, 4'd1, 1, 3'd0);
    for (int i = 0; i < 20 && !bus.out_valid; i++) cycle();
    held_data = bus.out_data;
    check_val("bp_data_value", held_data, 16'h000F);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_val("bp_valid_held", bus.out_valid, 1);
      check_val("bp_data_stable", bus.out_data, held_data);
      check_val("bp_id_stable", bus.out_id, 0);
      check_val("bp_ready1_low", bus.req1_ready, 0);
    end
    bus.out_ready = 1;
    cycle();
    check_val("bp_next_grant", bus.req1_ready, 1);
    cycle();
    check_val("bp_hs1", hs1_q, 1);
    set_req(1, 0, '0, '0, 0, '0);
    wait_idle();

    // Reset during RUN: no result, and requester 0 is favoured again afterwards.
    set_req(0, 1, 16'hBEEF, 4'd0, 0, 3'd7);
    wait_accept(0);
    set_req(0, 0, '0, '0, 0, '0);
    repeat (3) cycle();
    reset = 1;
    cycle();
    reset = 0;
    for (int i = 0; i < 12; i++) begin
      check_val("abort_out_valid", bus.out_valid, 0);
      check_val("abort_busy", busy, 0);
      cycle();
    end
    set_req(0, 1, 16'h0001, 4'd1, 1, 3'd0);
    set_req(1, 1, 16'h0002, 4'd1, 1, 3'd0);
    cycle();
    check_val("post_reset_grant0", hs0_q, 1);
    set_req(0, 0, '0, '0, 0, '0);
    set_req(1, 0, '0, '0, 0, '0);
    wait_idle();

    // Random traffic, including withdrawn requests, backpressure and rare resets.
    for (int c = 0; c < 1500; c++) begin
      if (hs0_q || !bus.req0_valid) begin
        if ($urandom_range(0, 9) < 6) set_rand_req(0); else bus.req0_valid = 0;
      end else if ($urandom_range(0, 19) == 0) bus.req0_valid = 0;
      if (hs1_q || !bus.req1_valid) begin
        if ($urandom_range(0, 9) < 6) set_rand_req(1); else bus.req1_valid = 0;
      end else if ($urandom_range(0, 19) == 0) bus.req1_valid = 0;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 399) == 0);
      cycle();
    end
    reset = 0;
    bus.out_ready = 1;
    set_req(0, 0, '0, '0, 0, '0);
    set_req(1, 0, '0, '0, 0, '0);
    cycle();
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
